// File: rtl/bp_update_queue.sv
// bp_update_queue
// ---------------------------------------------------------------------------
// Purpose: the branch unit can resolve up to two branches per cycle, but the
// 2-bit counter table has only one write port. This block funnels both update
// slots through a DEPTH-entry FIFO. It writes one entry per cycle to the table
// whenever the FIFO holds anything.
//
// Handshake: upd_ready is advisory only. It is high when two entries are
// certainly free (count <= DEPTH-2), and it depends on registered state alone.
// The block still attempts every update presented while ready is low. The
// older updates are accepted up to the free-slot count. Any update beyond that
// is dropped, and the drop sets the sticky overflow flag. On the table side
// there is no back-pressure: the table accepts the write in every cycle that
// we is high.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   upd_valid0/addr0/taken0     update slot 0 (older in program order)
//   upd_valid1/addr1/taken1     update slot 1 (younger)
//   upd_ready                   two entries are guaranteed free
//   we, waddr, br_taken         head entry presented to the counter table
//   count                       occupied entries (0..DEPTH)
//   overflow                    sticky: an update was dropped since reset
// ---------------------------------------------------------------------------
module bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_valid0,
  input  logic [AW-1:0]              upd_addr0,
  input  logic                       upd_taken0,
  input  logic                       upd_valid1,
  input  logic [AW-1:0]              upd_addr1,
  input  logic                       upd_taken1,
  output logic                       upd_ready,
  output logic                       we,
  output logic [AW-1:0]              waddr,
  output logic                       br_taken,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Each entry is {addr, taken}.
  logic [AW:0]    r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;

  logic           w_deq;
  logic [CW-1:0]  w_free;
  logic [1:0]     w_req;
  logic [1:0]     w_enq;
  logic           w_drop;
  logic [AW:0]    w_first;
  logic [AW:0]    w_second;
  logic [AW:0]    w_head;

  // The head entry leaves the FIFO in every non-empty cycle. The slot it
  // vacates is available to this same cycle's enqueue.
  assign w_deq  = (r_count != '0);
  assign w_free = DEPTH_C - r_count + CW'(w_deq);
  assign w_req  = 2'(upd_valid0) + 2'(upd_valid1);

  // w_free only drops below w_req when it is 0 or 1, so the low two bits hold
  // the whole value in that branch.
  assign w_enq  = (w_free >= CW'(w_req)) ? w_req : w_free[1:0];
  assign w_drop = (w_free < CW'(w_req));

  // Pack the accepted updates oldest-first. A lone slot-1 update becomes the
  // first (and only) entry, and it lands at the write pointer.
  assign w_first  = upd_valid0 ? {upd_addr0, upd_taken0} : {upd_addr1, upd_taken1};
  assign w_second = {upd_addr1, upd_taken1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_enq);
      r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the outputs are masked whenever count is 0.
  // Writes are gated by rst_n so that updates arriving during reset are
  // ignored.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_enq != 2'd0) begin
        r_mem[r_wr_ptr] <= w_first;
      end
      if (w_enq == 2'd2) begin
        // The pointer add wraps modulo DEPTH, so a straddling pair writes
        // entries DEPTH-1 and 0.
        r_mem[r_wr_ptr + PW'(1)] <= w_second;
      end
    end
  end

  assign w_head    = w_deq ? r_mem[r_rd_ptr] : '0;
  assign we        = w_deq;
  assign waddr     = w_head[AW:1];
  assign br_taken  = w_head[0];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign upd_ready = (r_count <= CW'(DEPTH - 2));

endmodule

// File: tb/tb_bp_update_queue.sv
// Testbench for bp_update_queue. A reference FIFO is kept as a SystemVerilog
// queue of {addr, taken} entries. The bench updates it once per rising edge
// using the queue's behavioural rules, then compares every output at #1 after
// the edge. Directed scenarios add checks against fixed constants.
module tb_bp_update_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          upd_valid0, upd_taken0, upd_valid1, upd_taken1;
  logic [AW-1:0] upd_addr0, upd_addr1;
  logic          upd_ready, we, br_taken, overflow;
  logic [AW-1:0] waddr;
  logic [CW-1:0] count;

  bp_update_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid0 (upd_valid0),
    .upd_addr0  (upd_addr0),
    .upd_taken0 (upd_taken0),
    .upd_valid1 (upd_valid1),
    .upd_addr1  (upd_addr1),
    .upd_taken1 (upd_taken1),
    .upd_ready  (upd_ready),
    .we         (we),
    .waddr      (waddr),
    .br_taken   (br_taken),
    .count      (count),
    .overflow   (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [AW:0] exp_q[$];
  bit          exp_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour at one rising edge.
  task automatic model_edge(input bit r, input bit v0, input logic [AW-1:0] a0, input bit t0,
                            input bit v1, input logic [AW-1:0] a1, input bit t1);
    int free;
    if (!r) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      free = DEPTH - exp_q.size();
      if (v0) begin
        if (free > 0) begin exp_q.push_back({a0, t0}); free--; end
        else exp_ovf = 1'b1;
      end
      if (v1) begin
        if (free > 0) begin exp_q.push_back({a1, t1}); free--; end
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({tag, ".we"},       32'(we),        32'(exp_q.size() != 0));
    chk({tag, ".waddr"},    32'(waddr),     32'(head[AW:1]));
    chk({tag, ".br_taken"}, 32'(br_taken),  32'(head[0]));
    chk({tag, ".count"},    32'(count),     32'(exp_q.size()));
    chk({tag, ".ready"},    32'(upd_ready), 32'(exp_q.size() <= DEPTH - 2));
    chk({tag, ".overflow"}, 32'(overflow),  32'(exp_ovf));
  endtask

  // driver: one clock cycle with the given inputs, then model update and check
  task automatic cycle(input string tag, input bit r,
                       input bit v0, input logic [AW-1:0] a0, input bit t0,
                       input bit v1, input logic [AW-1:0] a1, input bit t1);
    rst_n = r;
    upd_valid0 = v0; upd_addr0 = a0; upd_taken0 = t0;
    upd_valid1 = v1; upd_addr1 = a1; upd_taken1 = t1;
    @(posedge clk);
    model_edge(r, v0, a0, t0, v1, a1, t1);
    #1;
    check_all(tag);
    rst_n = 1'b1;
    upd_valid0 = 1'b0; upd_valid1 = 1'b0;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    upd_valid0 = 1'b0; upd_addr0 = '0; upd_taken0 = 1'b0;
    upd_valid1 = 1'b0; upd_addr1 = '0; upd_taken1 = 1'b0;
    exp_ovf = 1'b0;

    // Reset, with inputs active that must be ignored.
    cycle("rst0", 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 5'd7, 1'b0);
    cycle("rst1", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst.we", 32'(we), 0);
    chk("rst.waddr", 32'(waddr), 0);
    chk("rst.taken", 32'(br_taken), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.ready", 32'(upd_ready), 1);
    chk("rst.ovf", 32'(overflow), 0);

    // Single update.
    cycle("single", 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, '0, 1'b0);
    chk("single.we", 32'(we), 1);
    chk("single.waddr", 32'(waddr), 5);
    chk("single.taken", 32'(br_taken), 1);
    idle("single_idle");
    chk("single2.we", 32'(we), 0);
    chk("single2.count", 32'(count), 0);

    // Dual update to the same address: both are kept, in slot order.
    cycle("dual", 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0);
    chk("dual1.waddr", 32'(waddr), 3);
    chk("dual1.taken", 32'(br_taken), 1);
    idle("dual_idle1");
    chk("dual2.waddr", 32'(waddr), 3);
    chk("dual2.taken", 32'(br_taken), 0);
    idle("dual_idle2");

    // Fill with three back-to-back dual updates.
    cycle("fill1", 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 5'd2, 1'b1);
    chk("fill1.count", 32'(count), 2);
    cycle("fill2", 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd6, 1'b0);
    chk("fill2.count", 32'(count), 3);
    chk("fill2.ready", 32'(upd_ready), 0);
    cycle("fill3", 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 5'd10, 1'b1);
    chk("fill3.count", 32'(count), 4);

    // Overflow: only slot 0 fits into the slot freed by the dequeue.
    cycle("ovf", 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 5'd13, 1'b0);
    chk("ovf.count", 32'(count), 4);
    chk("ovf.flag", 32'(overflow), 1);
    for (int i = 0; i < 4; i++) idle("drain");
    chk("drain.count", 32'(count), 0);
    chk("drain.ovf", 32'(overflow), 1);

    // Wrap: a single update moves both pointers from 2 to 3. The following
    // dual update then straddles the wrap. Mixed updates follow, checked
    // in order by the scoreboard.
    cycle("wrap_pre", 1'b1, 1'b1, 5'd20, 1'b1, 1'b0, '0, 1'b0);
    idle("wrap_pre_idle");
    cycle("wrap", 1'b1, 1'b1, 5'd21, 1'b0, 1'b1, 5'd22, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle("wrap_mix", 1'b1, 1'(i % 2), 5'(i + 24), 1'(i % 3 == 0),
            1'b1, 5'(i + 16), 1'(i % 2 == 0));
    end
    for (int i = 0; i < 5; i++) idle("wrap_drain");

    // Mid-operation reset discards the queued entries.
    cycle("mr1", 1'b1, 1'b1, 5'd11, 1'b1, 1'b1, 5'd14, 1'b0);
    cycle("mr2", 1'b1, 1'b1, 5'd15, 1'b0, 1'b1, 5'd17, 1'b1);
    chk("mr.count", 32'(count), 3);
    cycle("mr_rst", 1'b0, 1'b1, 5'd30, 1'b1, 1'b0, '0, 1'b0);
    chk("mr.count0", 32'(count), 0);
    chk("mr.we0", 32'(we), 0);
    chk("mr.ovf0", 32'(overflow), 0);
    idle("mr_after1");
    chk("mr.no_stale", 32'(we), 0);
    idle("mr_after2");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 60) != 0),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
